shift_scanner: RTL and testbench

- Parametrised one-hot position scanner: a single set bit sweeps across a WIDTH-bit output, then dwells at its home position before the next sweep.
- Successor to the fixed 8-bit bounce counter. Adds configurable width, home dwell length and step rate, three sweep modes, an enable, and status outputs.
- Drives LED bars and scan-select lines in display and demo designs.

---
 rtl/shift_scanner_pkg.sv | 20 ++
 rtl/shift_scanner_step_tick.sv | 39 +++
 rtl/shift_scanner.sv | 148 ++++++++++++++
 tb/tb_shift_scanner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_scanner_pkg.sv
// rtl/shift_scanner_pkg.sv - shared mode constants, state encoding and mode helper
// Contents: MODE_* sweep mode codes, state_e FSM encoding, norm_mode() helper.
package shift_scanner_pkg;

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_WRAP_L = 2'b01;
  localparam logic [1:0] MODE_WRAP_R = 2'b10;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The reserved code 2'b11 behaves as bounce; folding it here keeps the
  // latched mode register limited to the three real modes.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_WRAP_L || m == MODE_WRAP_R) ? m : MODE_BOUNCE;
  endfunction

endpackage

// File: rtl/shift_scanner_step_tick.sv
// rtl/shift_scanner_step_tick.sv - enabled divide-by-STEP_DIV step tick generator
// Ports: clk_i clock, reset_i sync active-low reset, en_i count enable,
//        clear_i forces the divider to zero, tick_o high during the step cycle.
module step_tick #(
  parameter int STEP_DIV = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  assign tick_o = en_i && !clear_i && (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = tick_o ? '0 : div_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/shift_scanner.sv
// rtl/shift_scanner.sv - one-hot position scanner with home dwell and three sweep modes
// Ports: clk rising-edge clock, reset sync active-low, en freezes all state when low,
//        mode sweep mode (sampled at sweep start), count one-hot position,
//        dir 1 = toward MSB, busy high in RUN, sweep_done one-cycle end-of-sweep pulse.
module shift_scanner
  import shift_scanner_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 3,
  parameter int STEP_DIV    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             sweep_done
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] POS_LSB   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] POS_MSB   = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             step;
  logic [1:0]       start_mode;
  logic [WIDTH-1:0] shl, shr;

  step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (en),
    .clear_i (state_q == ST_HOLD),
    .tick_o  (step)
  );

  assign start_mode = norm_mode(mode);
  assign shl        = {count_q[WIDTH-2:0], 1'b0};
  assign shr        = {1'b0, count_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dir_d      = dir_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    if (en) begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
            mode_d     = start_mode;
            if (start_mode == MODE_WRAP_R) begin
              count_d = POS_MSB;
              dir_d   = 1'b0;
            end else begin
              count_d = POS_LSB;
              dir_d   = 1'b1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
        ST_RUN: begin
          if (step) begin
            case (mode_q)
              MODE_WRAP_L: begin
                if (count_q[WIDTH-1]) begin
                  count_d = POS_LSB;
                  state_d = ST_HOLD;
                  done_d  = 1'b1;
                end else begin
                  count_d = shl;
                end
              end
              MODE_WRAP_R: begin
                if (count_q[0]) begin
                  count_d = POS_MSB;
                  state_d = ST_HOLD;
                  done_d  = 1'b1;
                end else begin
                  count_d = shr;
                end
              end
              default: begin
                // Bounce: the turn at the MSB moves immediately, while arrival
                // back at the LSB costs one extra step that ends the sweep.
                if (dir_q) begin
                  if (count_q[WIDTH-1]) begin
                    count_d = shr;
                    dir_d   = 1'b0;
                  end else begin
                    count_d = shl;
                  end
                end else if (count_q[0]) begin
                  state_d = ST_HOLD;
                  dir_d   = 1'b1;
                  done_d  = 1'b1;
                end else begin
                  count_d = shr;
                end
              end
            endcase
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_HOLD;
      count_q    <= POS_LSB;
      dir_q      <= 1'b1;
      hold_cnt_q <= '0;
      mode_q     <= MODE_BOUNCE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign count      = count_q;
  assign dir        = dir_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_shift_scanner.sv
// tb/tb_shift_scanner.sv - self-checking bench for shift_scanner (three parameter sets)
module tb_shift_scanner;

  localparam int PW [3] = '{8, 4, 8};
  localparam int PH [3] = '{3, 3, 3};
  localparam int PD [3] = '{1, 1, 3};

  logic       clk = 1'b0;
  logic       rst [3];
  logic       en_s [3];
  logic [1:0] md [3];

  logic [7:0] c0, c2;
  logic [3:0] c1;
  logic       d0, b0, s0, d1, b1, s1, d2, b2, s2;
  logic [10:0] act [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_scanner #(.WIDTH(8), .HOLD_CYCLES(3), .STEP_DIV(1)) u0 (
    .clk(clk), .reset(rst[0]), .en(en_s[0]), .mode(md[0]),
    .count(c0), .dir(d0), .busy(b0), .sweep_done(s0));
  shift_scanner #(.WIDTH(4), .HOLD_CYCLES(3), .STEP_DIV(1)) u1 (
    .clk(clk), .reset(rst[1]), .en(en_s[1]), .mode(md[1]),
    .count(c1), .dir(d1), .busy(b1), .sweep_done(s1));
  shift_scanner #(.WIDTH(8), .HOLD_CYCLES(3), .STEP_DIV(3)) u2 (
    .clk(clk), .reset(rst[2]), .en(en_s[2]), .mode(md[2]),
    .count(c2), .dir(d2), .busy(b2), .sweep_done(s2));

  assign act[0] = {c0, d0, b0, s0};
  assign act[1] = {4'b0, c1, d1, b1, s1};
  assign act[2] = {c2, d2, b2, s2};

  task automatic chk(input string name, input int inst, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", name, inst, $time, a, x);
    end
  endtask

  // Behavioural model: position as an integer index, phase as run flag plus counters.
  int pos [3], hc [3], dc [3], mm [3], e [3];
  bit dir_m [3], run_m [3], done_m [3], valid [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst[i]) begin
        pos[i] = 0; dir_m[i] = 1; run_m[i] = 0; hc[i] = 0; dc[i] = 0;
        mm[i] = 0; done_m[i] = 0; e[i] = 0; valid[i] = 1;
      end else if (valid[i]) begin
        e[i]++;
        done_m[i] = 0;
        if (en_s[i]) begin
          if (!run_m[i]) begin
            if (hc[i] == PH[i] - 1) begin
              run_m[i] = 1; hc[i] = 0; dc[i] = 0;
              mm[i] = (md[i] == 2'd3) ? 0 : int'(md[i]);
              if (mm[i] == 2) begin pos[i] = PW[i] - 1; dir_m[i] = 0; end
              else begin pos[i] = 0; dir_m[i] = 1; end
            end else hc[i]++;
          end else if (dc[i] < PD[i] - 1) begin
            dc[i]++;
          end else begin
            dc[i] = 0;
            if (mm[i] == 1) begin
              if (pos[i] == PW[i] - 1) begin pos[i] = 0; run_m[i] = 0; done_m[i] = 1; end
              else pos[i]++;
            end else if (mm[i] == 2) begin
              if (pos[i] == 0) begin pos[i] = PW[i] - 1; run_m[i] = 0; done_m[i] = 1; end
              else pos[i]--;
            end else if (dir_m[i]) begin
              if (pos[i] == PW[i] - 1) begin pos[i]--; dir_m[i] = 0; end
              else pos[i]++;
            end else if (pos[i] == 0) begin
              run_m[i] = 0; dir_m[i] = 1; done_m[i] = 1;
            end else pos[i]--;
          end
        end
      end
    end
  end

  // Hand-computed pins: instance, edge after reset, count, dir, busy, sweep_done.
  typedef struct { int inst; int ed; logic [7:0] c; logic d; logic b; logic s; } lit_t;
  lit_t lits [24] = '{
    '{0, 1, 8'h01, 1, 0, 0}, '{0, 3, 8'h01, 1, 1, 0}, '{0, 4, 8'h02, 1, 1, 0},
    '{0, 10, 8'h80, 1, 1, 0}, '{0, 11, 8'h40, 0, 1, 0}, '{0, 17, 8'h01, 0, 1, 0},
    '{0, 18, 8'h01, 1, 0, 1}, '{0, 19, 8'h01, 1, 0, 0}, '{0, 21, 8'h01, 1, 1, 0},
    '{0, 36, 8'h01, 1, 0, 1},
    '{1, 1, 8'h01, 1, 0, 0}, '{1, 3, 8'h08, 0, 1, 0}, '{1, 4, 8'h04, 0, 1, 0},
    '{1, 6, 8'h01, 0, 1, 0}, '{1, 7, 8'h08, 0, 0, 1}, '{1, 10, 8'h08, 0, 1, 0},
    '{1, 14, 8'h08, 0, 0, 1},
    '{2, 3, 8'h01, 1, 1, 0}, '{2, 5, 8'h01, 1, 1, 0}, '{2, 6, 8'h02, 1, 1, 0},
    '{2, 24, 8'h80, 1, 1, 0}, '{2, 27, 8'h40, 0, 1, 0}, '{2, 47, 8'h01, 0, 1, 0},
    '{2, 48, 8'h01, 1, 0, 1}
  };

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i]) begin
        chk("model", i, 32'(act[i]),
            32'({8'(8'd1 << pos[i]), dir_m[i], run_m[i], done_m[i]}));
      end
    end
    for (int k = 0; k < 24; k++) begin
      if (valid[lits[k].inst] && e[lits[k].inst] == lits[k].ed) begin
        chk($sformatf("pin_e%0d", lits[k].ed), lits[k].inst, 32'(act[lits[k].inst]),
            32'({lits[k].c, lits[k].d, lits[k].b, lits[k].s}));
      end
    end
  end

  int n;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; en_s[i] = 1'b1; valid[i] = 0;
    end
    md[0] = 2'b00; md[1] = 2'b10; md[2] = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    repeat (45) @(negedge clk);

    // Freeze at 0x10 on the way up: 5 cycles frozen, then 11 enabled edges to done.
    n = 0;
    do begin @(negedge clk); n++; end while (!(c0 == 8'h10 && d0 && b0) && n < 100);
    chk("find_10", 0, n < 100, 1);
    en_s[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("frozen", 0, {c0, d0, b0, s0}, {8'h10, 1'b1, 1'b1, 1'b0});
    end
    en_s[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s0 && n < 100);
    chk("resume_len", 0, n, 11);

    // Mode change mid-sweep only takes effect on the next sweep.
    n = 0;
    do begin @(negedge clk); n++; end while (!(c0 == 8'h20 && d0 && b0) && n < 100);
    chk("find_20", 0, n < 100, 1);
    md[0] = 2'b01;
    n = 0;
    do begin @(negedge clk); n++; end while (!s0 && n < 100);
    chk("still_bounce", 0, n, 10);
    n = 0;
    do begin @(negedge clk); n++; end while (!s0 && n < 100);
    chk("wrap_l_period", 0, n, 11);
    md[0] = 2'b00;

    // Reset while heading down at 0x40; reserved mode afterwards acts as bounce.
    n = 0;
    do begin @(negedge clk); n++; end while (!(c0 == 8'h40 && !d0 && b0) && n < 100);
    chk("find_40", 0, n < 100, 1);
    rst[0] = 1'b0;
    md[0] = 2'b11;
    @(negedge clk);
    chk("mid_reset", 0, {c0, d0, b0, s0}, {8'h01, 1'b1, 1'b0, 1'b0});
    rst[0] = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
